apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns one response pulse per finished transfer. A transfer
// whose completer holds pready low for TIMEOUT_CYCLES ACCESS cycles is aborted
// and reported as a timeout.
//
// Handshake: a command moves on a rising pclk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high in IDLE and in ACCESS while pready
// is high, so a new command can chain onto a completing transfer. The
// requester must hold its command stable until it is taken. rsp_valid is a
// single-cycle pulse and has no back-pressure.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  // command side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  // response side
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  // APB requester outputs
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  output logic                    pselx,
  output logic                    penable,
  output logic                    pwrite,
  // APB completer inputs
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr,
  // FSM state for checkers: 0 = IDLE, 1 = SETUP, 2 = ACCESS
  output logic [1:0]              dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // The counter has to be able to reach TIMEOUT_CYCLES itself.
  localparam int WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WAIT_WIDTH-1:0] wait_q;
  logic                  load_cmd;
  logic                  complete;
  logic                  abort;

  assign dbg_state = state_q;

  // Next-state and handshake decode. pready is checked before the timeout,
  // so a ready that arrives on the last allowed cycle completes normally.
  // cmd_ready is low on an abort edge because pready is low there.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    load_cmd  = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load_cmd = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          cmd_ready = 1'b1;
          complete  = 1'b1;
          if (cmd_valid) begin
            load_cmd = 1'b1;
            state_d  = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Wait counter: zero outside ACCESS, counts ACCESS cycles with pready low.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_q <= '0;
    end else if (state_q != ST_ACCESS) begin
      wait_q <= '0;
    end else if (!pready) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  // APB outputs. Address/control/data are captured only when a command is
  // taken, so they stay stable through SETUP and ACCESS and hold in IDLE.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
      pwrite  <= 1'b0;
      pselx   <= 1'b0;
      penable <= 1'b0;
    end else begin
      pselx   <= (state_d != ST_IDLE);
      penable <= (state_d == ST_ACCESS);
      if (load_cmd) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
        pprot  <= cmd_prot;
        pstrb  <= cmd_write ? cmd_strb : {STRB_WIDTH{1'b0}};
      end
    end
  end

  // Response: one pulse after completion or abort. Data and status fields
  // only change when a pulse is produced, otherwise they hold.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= complete | abort;
      if (complete) begin
        rsp_rdata   <= pwrite ? {DATA_WIDTH{1'b0}} : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
